// File: rtl/snake_pkg.sv
// Shared constants and types for the snake 7-seg link: 74HC595 frame layout
// and the receive-side FSM state type.
package snake_pkg;

    localparam int unsigned HC595_W = 14;
    localparam int unsigned SEG_MSB = 13;
    localparam int unsigned SEG_LSB = 6;
    localparam int unsigned SEL_MSB = 5;
    localparam int unsigned SEL_LSB = 0;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LATCH
    } hc595_state_t;

endpackage

// File: rtl/hc595_rx_monitor_sync_edge.sv
// Multi-flop input synchronizer with rising-edge detect, used for each
// asynchronous 74HC595 link pin.
module sync_edge #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;
    logic [STAGES:0]   arm_q, arm_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
        prev_d = sync_q[STAGES-1];
        arm_d  = {arm_q[STAGES-1:0], 1'b1};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            arm_q  <= '0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            arm_q  <= arm_d;
        end
    end

    // Edges are masked until the pipeline and history hold post-reset samples,
    // so a pin already high at reset release never reads as a rising edge.
    always_comb begin
        q    = sync_q[STAGES-1];
        rise = arm_q[STAGES] & sync_q[STAGES-1] & ~prev_q;
    end

endmodule

// File: rtl/hc595_rx_monitor.sv
// Receive-side monitor for the 74HC595 serial link: rebuilds shifted words,
// reports them on each storage-latch edge and flags wrong bit counts.
module hc595_rx_monitor
    import snake_pkg::*;
#(
    parameter int unsigned SHIFT_W     = HC595_W,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               shcp,
    input  logic               stcp,
    input  logic               ds,
    input  logic               oe,
    output logic [SHIFT_W-1:0] frame_data,
    output logic [SHIFT_W-1:0] q_out,
    output logic               frame_valid,
    output logic               frame_err,
    output logic [4:0]         bit_cnt
);

    logic shcp_rise, stcp_rise, ds_s, oe_s;
    logic shcp_s_unused, stcp_s_unused, ds_rise_unused, oe_rise_unused;

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_shcp (
        .clk(clk), .rst(rst), .d(shcp), .q(shcp_s_unused), .rise(shcp_rise)
    );
    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_stcp (
        .clk(clk), .rst(rst), .d(stcp), .q(stcp_s_unused), .rise(stcp_rise)
    );
    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_ds (
        .clk(clk), .rst(rst), .d(ds), .q(ds_s), .rise(ds_rise_unused)
    );
    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_oe (
        .clk(clk), .rst(rst), .d(oe), .q(oe_s), .rise(oe_rise_unused)
    );

    hc595_state_t       state_q, state_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic [4:0]         cnt_q, cnt_d, cnt_inc;
    logic [SHIFT_W-1:0] snap_data_q, snap_data_d;
    logic               snap_err_q, snap_err_d;
    logic [4:0]         snap_cnt_q, snap_cnt_d;
    logic [SHIFT_W-1:0] frame_data_q, frame_data_d;
    logic               frame_valid_q, frame_valid_d;
    logic               frame_err_q, frame_err_d;
    logic [4:0]         bit_cnt_q, bit_cnt_d;

    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        cnt_d         = cnt_q;
        snap_data_d   = snap_data_q;
        snap_err_d    = snap_err_q;
        snap_cnt_d    = snap_cnt_q;
        frame_data_d  = frame_data_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        bit_cnt_d     = cnt_q;
        cnt_inc       = (cnt_q == 5'd31) ? 5'd31 : cnt_q + 5'd1;

        if (shcp_rise) begin
            shift_d = {shift_q[SHIFT_W-2:0], ds_s};
        end

        // The word is snapshotted on the stcp edge itself so a bit shifted in
        // the same cycle (tied clocks) belongs to the next frame; a stray
        // latch from IDLE takes the same path and reports count 0.
        unique case (state_q)
            IDLE, SHIFT: begin
                if (stcp_rise) begin
                    snap_data_d = shift_q;
                    snap_err_d  = (cnt_q != 5'(SHIFT_W));
                    snap_cnt_d  = cnt_q;
                    cnt_d       = shcp_rise ? 5'd1 : 5'd0;
                    state_d     = LATCH;
                end else if (shcp_rise) begin
                    cnt_d   = cnt_inc;
                    state_d = SHIFT;
                end
            end
            LATCH: begin
                frame_valid_d = 1'b1;
                frame_data_d  = snap_data_q;
                frame_err_d   = snap_err_q;
                bit_cnt_d     = snap_cnt_q;
                if (shcp_rise) begin
                    cnt_d = cnt_inc;
                end
                state_d = (shcp_rise || cnt_q != 5'd0) ? SHIFT : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            shift_q       <= '0;
            cnt_q         <= '0;
            snap_data_q   <= '0;
            snap_err_q    <= 1'b0;
            snap_cnt_q    <= '0;
            frame_data_q  <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            bit_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            cnt_q         <= cnt_d;
            snap_data_q   <= snap_data_d;
            snap_err_q    <= snap_err_d;
            snap_cnt_q    <= snap_cnt_d;
            frame_data_q  <= frame_data_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            bit_cnt_q     <= bit_cnt_d;
        end
    end

    always_comb begin
        frame_data  = frame_data_q;
        frame_valid = frame_valid_q;
        frame_err   = frame_err_q;
        bit_cnt     = bit_cnt_q;
        q_out       = oe_s ? '0 : frame_data_q;
    end

endmodule

// File: tb/tb_hc595_rx_monitor.sv
// Directed self-checking bench for hc595_rx_monitor: drives the serial link
// slowly relative to clk and checks latched words, errors and counts.
module tb_hc595_rx_monitor;

    localparam int W = 14;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         shcp = 1'b1, stcp = 1'b1, ds = 1'b0, oe = 1'b0;
    logic [W-1:0] frame_data, q_out;
    logic         frame_valid, frame_err;
    logic [4:0]   bit_cnt;

    int checks = 0;
    int errors = 0;

    hc595_rx_monitor #(.SHIFT_W(W), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .shcp(shcp), .stcp(stcp), .ds(ds), .oe(oe),
        .frame_data(frame_data), .q_out(q_out), .frame_valid(frame_valid),
        .frame_err(frame_err), .bit_cnt(bit_cnt)
    );

    always #5 clk = ~clk;

    // Monitor: records each frame_valid pulse and the bit_cnt one cycle later.
    int         cyc = 0;
    int         fv_count = 0;
    int         fv_cyc = 0;
    int         consec = 0;
    logic [W-1:0] fv_data = '0;
    logic       fv_err = 1'b0;
    logic [4:0] fv_bitcnt = '0;
    logic [4:0] fv_bitcnt_next = '0;
    logic       want_next = 1'b0;
    logic       prev_fv = 1'b0;

    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (want_next) begin
            fv_bitcnt_next = bit_cnt;
            want_next = 1'b0;
        end
        if (frame_valid === 1'b1) begin
            fv_count  = fv_count + 1;
            fv_cyc    = cyc;
            fv_data   = frame_data;
            fv_err    = frame_err;
            fv_bitcnt = bit_cnt;
            want_next = 1'b1;
            if (prev_fv) consec = consec + 1;
        end
        prev_fv = (frame_valid === 1'b1);
    end

    int start_cyc;
    int fv_before;

    task automatic send_bit(input logic b);
        @(negedge clk);
        ds = b;
        shcp = 1'b0;
        repeat (4) @(negedge clk);
        shcp = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_word(input logic [15:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic latch_frame();
        @(negedge clk);
        stcp = 1'b1;
        start_cyc = cyc;
        fv_before = fv_count;
        repeat (4) @(negedge clk);
        stcp = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (5) @(negedge clk);
        checks++; if (frame_data !== '0 || bit_cnt !== '0 || frame_valid !== 1'b0 || frame_err !== 1'b0) begin
            errors++; $display("FAIL reset_hold: data=%h cnt=%0d fv=%b err=%b, required all 0", frame_data, bit_cnt, frame_valid, frame_err); end
        rst = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (fv_count !== 0) begin errors++; $display("FAIL reset_no_fv: fv_count=%0d, required 0", fv_count); end
        checks++; if (frame_data !== '0) begin errors++; $display("FAIL reset_data: %h, required 0", frame_data); end
        checks++; if (bit_cnt !== 5'd0) begin errors++; $display("FAIL reset_bitcnt: %0d, required 0", bit_cnt); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_err: %b, required 0", frame_err); end
        checks++; if (q_out !== '0) begin errors++; $display("FAIL reset_qout: %h, required 0", q_out); end
        shcp = 1'b0;
        stcp = 1'b0;
        repeat (6) @(negedge clk);
        checks++; if (fv_count !== 0) begin errors++; $display("FAIL reset_fall_no_fv: fv_count=%0d, required 0", fv_count); end
    endtask

    task automatic test_nominal();
        send_word(16'h2A5C, 14);
        latch_frame();
        checks++; if (fv_count - fv_before !== 1) begin errors++; $display("FAIL nom_fv_count: %0d pulses, required 1", fv_count - fv_before); end
        checks++; if (fv_cyc - start_cyc !== 4) begin errors++; $display("FAIL nom_latency: %0d clks, required 4", fv_cyc - start_cyc); end
        checks++; if (fv_data !== 14'h2A5C) begin errors++; $display("FAIL nom_data: %h, required 2a5c", fv_data); end
        checks++; if (fv_err !== 1'b0) begin errors++; $display("FAIL nom_err: %b, required 0", fv_err); end
        checks++; if (fv_bitcnt !== 5'd14) begin errors++; $display("FAIL nom_bitcnt: %0d, required 14", fv_bitcnt); end
        checks++; if (fv_bitcnt_next !== 5'd0) begin errors++; $display("FAIL nom_bitcnt_next: %0d, required 0", fv_bitcnt_next); end
        checks++; if (q_out !== 14'h2A5C) begin errors++; $display("FAIL nom_qout: %h, required 2a5c", q_out); end
    endtask

    task automatic test_short();
        // 10 new bits enter the low end; top 4 bits keep 2a5c's low nibble (c).
        send_word(16'h03C5, 10);
        latch_frame();
        checks++; if (fv_count - fv_before !== 1) begin errors++; $display("FAIL short_fv_count: %0d, required 1", fv_count - fv_before); end
        checks++; if (fv_data !== 14'h33C5) begin errors++; $display("FAIL short_data: %h, required 33c5", fv_data); end
        checks++; if (fv_err !== 1'b1) begin errors++; $display("FAIL short_err: %b, required 1", fv_err); end
        checks++; if (fv_bitcnt !== 5'd10) begin errors++; $display("FAIL short_bitcnt: %0d, required 10", fv_bitcnt); end
        checks++; if (fv_bitcnt_next !== 5'd0) begin errors++; $display("FAIL short_bitcnt_next: %0d, required 0", fv_bitcnt_next); end
    endtask

    task automatic test_long();
        send_word(16'hFF00, 16);
        latch_frame();
        checks++; if (fv_data !== 14'h3F00) begin errors++; $display("FAIL long_data: %h, required 3f00", fv_data); end
        checks++; if (fv_err !== 1'b1) begin errors++; $display("FAIL long_err: %b, required 1", fv_err); end
        checks++; if (fv_bitcnt !== 5'd16) begin errors++; $display("FAIL long_bitcnt: %0d, required 16", fv_bitcnt); end
    endtask

    logic [W-1:0] exp_shift;
    logic [W-1:0] last_latched;

    task automatic test_tied();
        logic [14:0] pat;
        pat = 15'h4D2B;
        exp_shift = 14'h3F00;
        fv_before = fv_count;
        for (int i = 14; i >= 0; i--) begin
            @(negedge clk);
            ds = pat[i];
            shcp = 1'b0;
            stcp = 1'b0;
            repeat (4) @(negedge clk);
            shcp = 1'b1;
            stcp = 1'b1;
            repeat (4) @(negedge clk);
            shcp = 1'b0;
            stcp = 1'b0;
            repeat (4) @(negedge clk);
            checks++; if (fv_data !== exp_shift) begin errors++; $display("FAIL tied_data[%0d]: %h, required %h", i, fv_data, exp_shift); end
            checks++; if (fv_bitcnt_next !== 5'd1) begin errors++; $display("FAIL tied_bitcnt[%0d]: %0d, required 1", i, fv_bitcnt_next); end
            last_latched = exp_shift;
            exp_shift = {exp_shift[W-2:0], pat[i]};
        end
        checks++; if (fv_count - fv_before !== 15) begin errors++; $display("FAIL tied_fv_count: %0d, required 15", fv_count - fv_before); end
        checks++; if (fv_err !== 1'b1) begin errors++; $display("FAIL tied_err: %b, required 1", fv_err); end
    endtask

    task automatic test_oe();
        @(negedge clk);
        oe = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (q_out !== '0) begin errors++; $display("FAIL oe_qout_off: %h, required 0", q_out); end
        checks++; if (frame_data !== last_latched) begin errors++; $display("FAIL oe_data_hold: %h, required %h", frame_data, last_latched); end
        oe = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (q_out !== last_latched) begin errors++; $display("FAIL oe_qout_on: %h, required %h", q_out, last_latched); end
    endtask

    task automatic test_reset_mid();
        send_word(16'h007F, 7);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (frame_data !== '0 || bit_cnt !== 5'd0) begin errors++; $display("FAIL midrst_clear: data=%h cnt=%0d, required 0/0", frame_data, bit_cnt); end
        repeat (6) @(negedge clk);
        send_word(16'h1B37, 14);
        latch_frame();
        checks++; if (fv_count - fv_before !== 1) begin errors++; $display("FAIL midrst_fv_count: %0d, required 1", fv_count - fv_before); end
        checks++; if (fv_data !== 14'h1B37) begin errors++; $display("FAIL midrst_data: %h, required 1b37", fv_data); end
        checks++; if (fv_err !== 1'b0) begin errors++; $display("FAIL midrst_err: %b, required 0", fv_err); end
        checks++; if (fv_bitcnt !== 5'd14) begin errors++; $display("FAIL midrst_bitcnt: %0d, required 14", fv_bitcnt); end
    endtask

    task automatic test_back_to_back();
        send_word(16'h0155, 14);
        latch_frame();
        send_word(16'h2AAA, 14);
        latch_frame();
        checks++; if (fv_data !== 14'h2AAA || fv_err !== 1'b0) begin errors++; $display("FAIL b2b_data: %h err=%b, required 2aaa err=0", fv_data, fv_err); end
        checks++; if (consec !== 0) begin errors++; $display("FAIL fv_consecutive: %0d, required 0", consec); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_short();
        test_long();
        test_tied();
        test_oe();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
